vga_scanout: RTL and testbench

Parametrised VGA scan-out engine. It generates the display timing for any resolution and fetches pixels from a synchronous framebuffer memory with a 32-bit read port. It unpacks 8-, 16- or 32-bit pixels from each memory word and expands them to 8:8:8 RGB, with optional 2x pixel/line doubling. It drives the VGA DAC pins directly, replacing the fixed 640x480 controller plus drawing-logic pair. All outputs are pipeline-aligned to a configurable memory read latency.

---
 rtl/vga_scanout.sv | 166 ++++++++++++++++
 tb/tb_vga_scanout.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// VGA scan-out engine: display timing, framebuffer word fetch, pixel unpack and
// RGB expansion. Every output lags its counter position by RD_LAT+2 clocks.
module vga_scanout #(
    parameter int HACTIVE = 640,
    parameter int HFP     = 16,
    parameter int HSYNC   = 96,
    parameter int HBP     = 48,
    parameter int VACTIVE = 480,
    parameter int VFP     = 10,
    parameter int VSYNC   = 2,
    parameter int VBP     = 33,
    parameter int BPP     = 8,
    parameter int ADDR_W  = 17,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              scale,
    input  logic [ADDR_W-1:0] fb_base,
    output logic              rden,
    output logic [ADDR_W-1:0] rdaddress,
    input  logic [31:0]       q,
    output logic              hsync,
    output logic              vsync,
    output logic              sync_b,
    output logic              blank_b,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              frame_start
);
    localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP;
    localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int PPW    = 32 / BPP;
    localparam int PPW_LG = (BPP == 8) ? 2 : (BPP == 16) ? 1 : 0;
    localparam int WPL    = HACTIVE / PPW;
    localparam int L      = RD_LAT + 2;
    localparam int D      = RD_LAT + 1;

    localparam logic [HW-1:0]     H_ACT  = HW'(HACTIVE);
    localparam logic [HW-1:0]     H_SB   = HW'(HACTIVE + HFP);
    localparam logic [HW-1:0]     H_SE   = HW'(HACTIVE + HFP + HSYNC);
    localparam logic [HW-1:0]     H_LAST = HW'(HTOTAL - 1);
    localparam logic [VW-1:0]     V_ACT  = VW'(VACTIVE);
    localparam logic [VW-1:0]     V_SB   = VW'(VACTIVE + VFP);
    localparam logic [VW-1:0]     V_SE   = VW'(VACTIVE + VFP + VSYNC);
    localparam logic [VW-1:0]     V_LAST = VW'(VTOTAL - 1);
    localparam logic [ADDR_W-1:0] WPL_A  = ADDR_W'(WPL);
    localparam logic [1:0]        IDX_MASK = 2'(PPW - 1);

    logic [HW-1:0]     h;
    logic [VW-1:0]     v;
    logic              enable_l, scale_l;
    logic [ADDR_W-1:0] line_base;
    logic              origin, en_eff, sc_eff, visible, fetch, hs_now, vs_now;
    logic [HW-1:0]     sx;
    logic [1:0]        pix_idx;
    logic [ADDR_W-1:0] base_eff;

    // At the frame origin the settings are being latched this very clock, so
    // the origin position itself must already see the incoming values.
    assign origin   = (h == '0) && (v == '0);
    assign en_eff   = origin ? enable  : enable_l;
    assign sc_eff   = origin ? scale   : scale_l;
    assign base_eff = origin ? fb_base : line_base;
    assign sx       = sc_eff ? (h >> 1) : h;
    assign pix_idx  = sx[1:0] & IDX_MASK;
    assign visible  = (h < H_ACT) && (v < V_ACT);
    assign fetch    = visible && en_eff && (pix_idx == 2'd0) && !(sc_eff && h[0]);
    assign hs_now   = !((h >= H_SB) && (h < H_SE));
    assign vs_now   = !((v >= V_SB) && (v < V_SE));

    logic [L-1:0]   hs_p, vs_p, bl_p, fs_p;
    logic [D-1:0]   ld_p, on_p;
    logic [1:0]     idx_p [D];
    logic [31:0]    word_reg, word_cur;
    logic [BPP-1:0] pix;
    logic [7:0]     r_x, g_x, b_x;

    // Stage RD_LAT lines up with q; the first pixel of a word takes it directly.
    assign word_cur = ld_p[RD_LAT] ? q : word_reg;
    assign pix      = BPP'(word_cur >> (int'(idx_p[RD_LAT]) * BPP));

    generate
        if (BPP == 8) begin : g_rgb332
            assign r_x = {pix[7:5], pix[7:5], pix[7:6]};
            assign g_x = {pix[4:2], pix[4:2], pix[4:3]};
            assign b_x = {4{pix[1:0]}};
        end else if (BPP == 16) begin : g_rgb565
            assign r_x = {pix[15:11], pix[15:13]};
            assign g_x = {pix[10:5], pix[10:9]};
            assign b_x = {pix[4:0], pix[4:2]};
        end else begin : g_rgb888
            logic [7:0] unused_alpha;
            assign unused_alpha = pix[31:24];
            assign r_x = pix[23:16];
            assign g_x = pix[15:8];
            assign b_x = pix[7:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h         <= '0;
            v         <= '0;
            enable_l  <= 1'b0;
            scale_l   <= 1'b0;
            line_base <= '0;
            rden      <= 1'b0;
            rdaddress <= '0;
            hs_p      <= '1;
            vs_p      <= '1;
            bl_p      <= '0;
            fs_p      <= '0;
            ld_p      <= '0;
            on_p      <= '0;
            for (int i = 0; i < D; i++) idx_p[i] <= 2'd0;
            word_reg  <= '0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end

            // line_base doubles as the latched fb_base and advances per source line.
            if (origin) begin
                enable_l  <= enable;
                scale_l   <= scale;
                line_base <= fb_base;
            end else if (h == H_LAST && v < V_ACT && (!scale_l || v[0])) begin
                line_base <= line_base + WPL_A;
            end

            rden      <= fetch;
            rdaddress <= base_eff + ADDR_W'(sx >> PPW_LG);

            hs_p <= {hs_p[L-2:0], hs_now};
            vs_p <= {vs_p[L-2:0], vs_now};
            bl_p <= {bl_p[L-2:0], visible};
            fs_p <= {fs_p[L-2:0], origin};
            ld_p <= {ld_p[D-2:0], fetch};
            on_p <= {on_p[D-2:0], visible && en_eff};
            idx_p[0] <= pix_idx;
            for (int i = 1; i < D; i++) idx_p[i] <= idx_p[i-1];

            word_reg <= word_cur;
            red      <= on_p[RD_LAT] ? r_x : 8'd0;
            green    <= on_p[RD_LAT] ? g_x : 8'd0;
            blue     <= on_p[RD_LAT] ? b_x : 8'd0;
        end
    end

    assign hsync       = hs_p[L-1];
    assign vsync       = vs_p[L-1];
    assign blank_b     = bl_p[L-1];
    assign frame_start = fs_p[L-1];
    assign sync_b      = 1'b0;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a small 16-bpp mode: per-cycle reference model of
// timing and pixels, a colour table, and directed scale/wrap/disable/reset runs.
module tb_vga_scanout;
    localparam int HA = 32, HFP = 4, HS = 6, HBP = 6;
    localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
    localparam int BPP = 16, ADDR_W = 8, RD_LAT = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int L = RD_LAT + 2;
    localparam int PPW = 32 / BPP;
    localparam int WPL = HA / PPW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b1;
    logic scale = 1'b0;
    logic [ADDR_W-1:0] fb_base = '0;
    logic rden, hsync, vsync, sync_b, blank_b, frame_start;
    logic [ADDR_W-1:0] rdaddress;
    logic [31:0] q;
    logic [7:0] red, green, blue;

    typedef struct {
        logic [31:0] word;
        logic [23:0] px0;
        logic [23:0] px1;
    } vec_t;
    vec_t tbl [4];

    int checks = 0;
    int errors = 0;
    int count = 0;
    bit chk_on = 0;
    bit wrap_seen = 0;
    int prev_addr = -1;
    logic [31:0] mem [256];
    logic [31:0] rd_pipe [RD_LAT];
    bit s_en [64];
    bit s_sc [64];
    int s_base [64];

    always #5 clk = ~clk;

    vga_scanout #(
        .HACTIVE(HA), .HFP(HFP), .HSYNC(HS), .HBP(HBP),
        .VACTIVE(VA), .VFP(VFP), .VSYNC(VS), .VBP(VBP),
        .BPP(BPP), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .scale(scale), .fb_base(fb_base),
        .rden(rden), .rdaddress(rdaddress), .q(q),
        .hsync(hsync), .vsync(vsync), .sync_b(sync_b), .blank_b(blank_b),
        .red(red), .green(green), .blue(blue), .frame_start(frame_start)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Edge counter since reset release plus the settings present at each frame origin.
    always @(posedge clk) begin
        if (!reset) begin
            count <= 0;
        end else begin
            if (count % FRAME == 0) begin
                s_en[(count / FRAME) % 64]   <= enable;
                s_sc[(count / FRAME) % 64]   <= scale;
                s_base[(count / FRAME) % 64] <= int'(fb_base);
            end
            count <= count + 1;
        end
        rd_pipe[0] <= rden ? mem[rdaddress] : $urandom;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign q = rd_pipe[RD_LAT-1];

    // Expected {hsync,vsync,blank_b,frame_start} and RGB for linear position p.
    function automatic void model_px(input int p, output logic [3:0] se, output logic [23:0] re);
        int h, v, f, sx, sy, a, r, g, b;
        logic [31:0] w;
        logic [15:0] px;
        se = 4'b1100;
        re = 24'h0;
        if (p < 0) return;
        h = p % HT;
        v = (p / HT) % VT;
        f = (p / FRAME) % 64;
        se[3] = !(h >= HA + HFP && h < HA + HFP + HS);
        se[2] = !(v >= VA + VFP && v < VA + VFP + VS);
        se[1] = (h < HA) && (v < VA);
        se[0] = (h == 0) && (v == 0);
        if (se[1] && s_en[f]) begin
            sx = s_sc[f] ? h / 2 : h;
            sy = s_sc[f] ? v / 2 : v;
            a = (s_base[f] + sy * WPL + sx / PPW) % 256;
            w = mem[a];
            px = (sx % 2 == 1) ? w[31:16] : w[15:0];
            r = int'(px[15:11]);
            g = int'(px[10:5]);
            b = int'(px[4:0]);
            re = {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
        end
    endfunction

    // Expected read strobe and address issued for linear position m.
    function automatic void model_rd(input int m, output logic rde, output logic [7:0] ae);
        int h, v, f, sx, sy;
        rde = 1'b0;
        ae = 8'h0;
        if (m < 0) return;
        h = m % HT;
        v = (m / HT) % VT;
        f = (m / FRAME) % 64;
        sx = s_sc[f] ? h / 2 : h;
        sy = s_sc[f] ? v / 2 : v;
        if (h < HA && v < VA && s_en[f] && (h % (s_sc[f] ? 2 * PPW : PPW)) == 0) begin
            rde = 1'b1;
            ae = 8'((s_base[f] + sy * WPL + sx / PPW) % 256);
        end
    endfunction

    always @(negedge clk) begin
        logic [3:0] se;
        logic [23:0] re;
        logic rde;
        logic [7:0] ae;
        #1;
        if (chk_on) begin
            if (!reset) begin
                se = 4'b1100; re = 24'h0; rde = 1'b0; ae = 8'h0;
            end else begin
                model_px(count - L, se, re);
                model_rd(count - 1, rde, ae);
            end
            chk("sync", {28'h0, hsync, vsync, blank_b, frame_start}, {28'h0, se});
            chk("rgb", {8'h0, red, green, blue}, {8'h0, re});
            chk("rden", {31'h0, rden}, {31'h0, rde});
            if (rde || !reset) chk("rdaddress", {24'h0, rdaddress}, {24'h0, ae});
            chk("sync_b", {31'h0, sync_b}, 32'h0);
            if (rden) begin
                if (prev_addr == 255 && rdaddress == 8'h00) wrap_seen = 1;
                prev_addr = int'(rdaddress);
            end
        end
    end

    task automatic wait_fs(input int budget);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (frame_start !== 1'b1 && t < budget);
        chk("frame_start_seen", {31'h0, frame_start}, 32'h1);
    endtask

    task automatic measure(output int bl, output int hs, output int vs, output int fs,
                           output int rd, output int nz);
        bl = 0; hs = 0; vs = 0; fs = 0; rd = 0; nz = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (blank_b === 1'b1) bl++;
            if (hsync === 1'b0) hs++;
            if (vsync === 1'b0) vs++;
            if (frame_start === 1'b1) fs++;
            if (rden === 1'b1) rd++;
            if ({red, green, blue} !== 24'h0) nz++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n, bl, hs, vs, fs, rd, nz;
        logic [23:0] exp_px;
        tbl[0] = '{32'hF800001F, 24'h0000FF, 24'hFF0000};
        tbl[1] = '{32'hFFFF0000, 24'h000000, 24'hFFFFFF};
        tbl[2] = '{32'h084107E0, 24'h00FF00, 24'h080808};
        tbl[3] = '{32'h5AAA8410, 24'h848284, 24'h5A5552};
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[i] = tbl[i].word;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1;
        chk("reset_idle", {4'h0, hsync, vsync, blank_b, rden, red, green, blue},
            {4'h0, 4'b1100, 24'h0});
        reset = 1'b1;

        // Colour table on the first eight pixels of the first frame.
        wait_fs(2 * FRAME);
        for (int i = 0; i < 8; i++) begin
            exp_px = (i % 2 == 1) ? tbl[i / 2].px1 : tbl[i / 2].px0;
            chk("table_rgb", {8'h0, red, green, blue}, {8'h0, exp_px});
            @(negedge clk);
        end

        // Random settings changes, frequently mid-frame.
        repeat (4 * FRAME) begin
            @(negedge clk);
            if ($urandom_range(0, 99) == 0) begin
                enable  = ($urandom_range(0, 3) != 0);
                scale   = 1'($urandom);
                fb_base = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(240, 255)) : 8'($urandom);
            end
        end

        // Base near the top of the address space, then a mid-frame scale toggle.
        enable = 1'b1;
        scale = 1'b0;
        fb_base = 8'hFC;
        wait_fs(2 * FRAME);
        wrap_seen = 0;
        prev_addr = -1;
        wait_fs(2 * FRAME);
        repeat (FRAME / 2) @(negedge clk);
        scale = 1'b1;
        wait_fs(2 * FRAME);
        chk("addr_wrap_seen", {31'h0, wrap_seen}, 32'h1);

        measure(bl, hs, vs, fs, rd, nz);
        chk("x2_blank_cnt", bl, VA * HA);
        chk("x2_hsync_low", hs, VT * HS);
        chk("x2_vsync_low", vs, VS * HT);
        chk("x2_fs_cnt", fs, 1);
        chk("x2_rden_cnt", rd, VA * HA / (2 * PPW));

        // Disabled frame: timing unchanged, no fetches, black pixels.
        enable = 1'b0;
        wait_fs(2 * FRAME);
        wait_fs(2 * FRAME);
        measure(bl, hs, vs, fs, rd, nz);
        chk("dis_blank_cnt", bl, VA * HA);
        chk("dis_hsync_low", hs, VT * HS);
        chk("dis_vsync_low", vs, VS * HT);
        chk("dis_fs_cnt", fs, 1);
        chk("dis_rden_cnt", rd, 0);
        chk("dis_rgb_nonzero", nz, 0);

        // Reset in the middle of a visible line.
        enable = 1'b1;
        n = 0;
        while (blank_b !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("reset_hold", {4'h0, hsync, vsync, blank_b, rden, red, green, blue},
                {4'h0, 4'b1100, 24'h0});
        end
        reset = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (hsync !== 1'b0 && n < 4 * HT);
        chk("first_hsync_fall", n, HA + HFP + L);

        repeat (FRAME) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
